// File: rtl/epp_fifo_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : epp_pkg
// Shared types and sizes for the EPP FIFO drain/pack controller.
// Revision: 1.0
// ============================================================================
package epp_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CAP  = 2'd1,
    SEND = 2'd2
  } state_e;

  // One-hot lane select for the byte being captured.
  function automatic logic [BYTES_PER_WORD-1:0] lane_bit(input logic [IDX_W-1:0] idx);
    lane_bit      = '0;
    lane_bit[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/epp_fifo_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : epp_fifo_drain_ctrl_if
// FIFO read port plus the outgoing word stream of the drain controller.
// Revision  : 1.0
// ============================================================================
interface epp_fifo_drain_ctrl_if;
  import epp_pkg::*;

  logic                      fifo_rden;
  logic [7:0]                fifo_dout;
  logic                      fifo_empty;
  logic [WORD_W-1:0]         m_tdata;
  logic [BYTES_PER_WORD-1:0] m_tkeep;
  logic                      m_tlast;
  logic                      m_tvalid;
  logic                      m_tready;

  modport master (
    output fifo_rden,
    input  fifo_dout,
    input  fifo_empty,
    output m_tdata,
    output m_tkeep,
    output m_tlast,
    output m_tvalid,
    input  m_tready
  );

  modport slave (
    input  fifo_rden,
    output fifo_dout,
    output fifo_empty,
    input  m_tdata,
    input  m_tkeep,
    input  m_tlast,
    input  m_tvalid,
    output m_tready
  );

endinterface
`default_nettype wire

// File: rtl/epp_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : epp_fifo_drain_ctrl
// Drains the EPP byte FIFO and packs bytes little-endian into 32-bit words.
// Revision: 1.0
// ============================================================================
module epp_fifo_drain_ctrl
  import epp_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  epp_fifo_drain_ctrl_if.master  bus,
  input  logic                   flush,
  output logic                   busy
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          byte_idx_q, byte_idx_d;
  logic [CNT_WIDTH-1:0]      to_cnt_q, to_cnt_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [WORD_W-1:0]         data_q, data_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic                      last_q, last_d;
  logic                      valid_q, valid_d;
  logic                      rden;
  logic                      pend_clr;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    to_cnt_d   = to_cnt_q;
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    valid_d    = valid_q;
    rden       = 1'b0;
    pend_clr   = 1'b0;

    unique case (state_q)
      FILL: begin
        if (!bus.fifo_empty) begin
          rden     = 1'b1;
          to_cnt_d = '0;
          state_d  = CAP;
        end else if ((byte_idx_q != '0) && (flush_pend_q || (to_cnt_q == TO_LAST))) begin
          state_d = SEND;
          valid_d = 1'b1;
          last_d  = 1'b1;
        end else if ((byte_idx_q == '0) && flush_pend_q) begin
          pend_clr = 1'b1;
        end else if (byte_idx_q != '0) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          to_cnt_d = '0;
        end
      end

      CAP: begin
        // fifo_dout is the byte requested by the rden of the previous FILL cycle
        data_d[{byte_idx_q, 3'b000} +: 8] = bus.fifo_dout;
        keep_d = keep_q | lane_bit(byte_idx_q);
        if (byte_idx_q == LAST_IDX) begin
          byte_idx_d = '0;
          state_d    = SEND;
          valid_d    = 1'b1;
          last_d     = 1'b0;
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
          state_d    = FILL;
        end
      end

      SEND: begin
        if (bus.m_tready) begin
          valid_d    = 1'b0;
          data_d     = '0;
          keep_d     = '0;
          last_d     = 1'b0;
          byte_idx_d = '0;
          to_cnt_d   = '0;
          state_d    = FILL;
          pend_clr   = last_q;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // A new pulse wins over a same-cycle clear so no request is lost.
    flush_pend_d = flush | (flush_pend_q & ~pend_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      byte_idx_q   <= '0;
      to_cnt_q     <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      to_cnt_q     <= to_cnt_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.fifo_rden = rden;
  assign bus.m_tdata   = data_q;
  assign bus.m_tkeep   = keep_q;
  assign bus.m_tlast   = last_q;
  assign bus.m_tvalid  = valid_q;
  assign busy          = (state_q != FILL) || (byte_idx_q != '0);

endmodule
`default_nettype wire
